// File: rtl/execute_stage_mdu.sv
// Execute stage: one-cycle ALU, branch and jump resolution plus an iterative
// shift-add multiplier / restoring divider in front of a one-entry output slot.
module execute_stage_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      kind,
    input  logic [3:0]      alu_op,
    input  logic            src_a_pc,
    input  logic            src_b_imm,
    input  logic [2:0]      funct3,
    input  logic            is_jalr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_addr
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [1:0] K_ALU = 2'd0;
    localparam logic [1:0] K_BR  = 2'd1;
    localparam logic [1:0] K_JMP = 2'd2;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  hi, lo, divisor;
    logic [2:0]       op_r;
    logic             neg_q, neg_r;

    logic [XLEN-1:0] op_a, op_b, alu_res, br_sum;
    logic [SH_W-1:0] shamt;
    logic            taken;
    logic            signed_a, signed_b, sa, sb;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] fast_res, fast_addr;
    logic            fast_redir;
    logic [XLEN:0]   sum, shifted, diff;
    logic [XLEN-1:0] addend, step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo, rem, fix_res;
    logic            slot_free, accept;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && slot_free;
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        op_a    = src_a_pc ? pc : rs1;
        op_b    = src_b_imm ? imm : rs2;
        shamt   = op_b[SH_W-1:0];
        alu_res = '0;
        unique case (alu_op)
            4'd0: alu_res = op_a + op_b;
            4'd1: alu_res = op_a - op_b;
            4'd2: alu_res = op_a << shamt;
            4'd3: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd4: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'd5: alu_res = op_a ^ op_b;
            4'd6: alu_res = op_a >> shamt;
            4'd7: alu_res = $signed(op_a) >>> shamt;
            4'd8: alu_res = op_a | op_b;
            4'd9: alu_res = op_a & op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        unique case (funct3)
            3'd0: taken = rs1 == rs2;
            3'd1: taken = rs1 != rs2;
            3'd4: taken = $signed(rs1) < $signed(rs2);
            3'd5: taken = $signed(rs1) >= $signed(rs2);
            3'd6: taken = rs1 < rs2;
            3'd7: taken = rs1 >= rs2;
            default: taken = 1'b0;
        endcase
    end

    // Operand signedness: divides use funct3[0] as "unsigned", MULH/MULHSU differ on rs2.
    always_comb begin
        signed_a = funct3[2] ? !funct3[0] : (funct3[0] ^ funct3[1]);
        signed_b = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01);
        sa       = signed_a && rs1[XLEN-1];
        sb       = signed_b && rs2[XLEN-1];
        mag_a    = sa ? (~rs1 + 1'b1) : rs1;
        mag_b    = sb ? (~rs2 + 1'b1) : rs2;
        div_zero = funct3[2] && (rs2 == '0);
        div_ovf  = funct3[2] && !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
        special  = div_zero || div_ovf;
        if (div_zero) spec_res = funct3[1] ? rs1 : '1;
        else          spec_res = funct3[1] ? '0 : rs1;
    end

    always_comb begin
        br_sum     = pc + imm;
        fast_res   = '0;
        fast_redir = 1'b0;
        fast_addr  = '0;
        unique case (kind)
            K_ALU: fast_res = alu_res;
            K_BR: begin
                fast_redir = taken;
                fast_addr  = taken ? br_sum : '0;
            end
            K_JMP: begin
                fast_res   = pc + XLEN'(4);
                fast_redir = 1'b1;
                fast_addr  = is_jalr ? ((rs1 + imm) & ~XLEN'(1)) : br_sum;
            end
            default: fast_res = spec_res;
        endcase
    end

    // One iteration: shift-add (multiplier in lo) or restoring divide (dividend in lo).
    always_comb begin
        addend  = lo[0] ? divisor : {XLEN{1'b0}};
        sum     = {1'b0, hi} + {1'b0, addend};
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        if (op_r[2]) begin
            if (diff[XLEN]) begin
                step_hi = shifted[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b0};
            end else begin
                step_hi = diff[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b1};
            end
        end else begin
            step_hi = sum[XLEN:1];
            step_lo = {sum[0], lo[XLEN-1:1]};
        end
    end

    always_comb begin
        prod   = {hi, lo};
        prod_s = neg_q ? (~prod + 1'b1) : prod;
        quo    = neg_q ? (~lo + 1'b1) : lo;
        rem    = neg_r ? (~hi + 1'b1) : hi;
        if (op_r[2])                fix_res = op_r[1] ? rem : quo;
        else if (op_r[1:0] == 2'b0) fix_res = prod_s[XLEN-1:0];
        else                        fix_res = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            hi            <= '0;
            lo            <= '0;
            divisor       <= '0;
            op_r          <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            out_valid     <= 1'b0;
            result        <= '0;
            redirect      <= 1'b0;
            redirect_addr <= '0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    if (kind == 2'd3 && !special) begin
                        hi      <= '0;
                        lo      <= mag_a;
                        divisor <= mag_b;
                        op_r    <= funct3;
                        neg_q   <= sa ^ sb;
                        neg_r   <= sa;
                        cnt     <= '0;
                        state   <= BUSY;
                    end else begin
                        out_valid     <= 1'b1;
                        result        <= fast_res;
                        redirect      <= fast_redir;
                        redirect_addr <= fast_addr;
                    end
                end
                BUSY: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) state <= FIX;
                end
                FIX: if (slot_free) begin
                    out_valid     <= 1'b1;
                    result        <= fix_res;
                    redirect      <= 1'b0;
                    redirect_addr <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_execute_stage_mdu.sv
// Scoreboard bench for execute_stage_mdu: single-cycle ops, iterative
// mul/div latency and signs, backpressure, flush and asynchronous reset.
module tb_execute_stage_mdu;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, flush;
    logic [31:0] rs1, rs2, imm, pc;
    logic [1:0]  kind;
    logic [3:0]  alu_op;
    logic        src_a_pc, src_b_imm, is_jalr;
    logic [2:0]  funct3;
    logic        out_valid, out_ready, redirect;
    logic [31:0] result, redirect_addr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  k;
        logic [3:0]  aop;
        logic [2:0]  f3;
        logic [31:0] a, b, im, p;
        logic [2:0]  fl;
        logic [31:0] res;
        logic        rd;
        logic [31:0] ad;
        int          lat;
    } vec_t;

    vec_t scb[$];

    execute_stage_mdu #(.XLEN(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .rs1(rs1), .rs2(rs2), .imm(imm), .pc(pc),
        .kind(kind), .alu_op(alu_op),
        .src_a_pc(src_a_pc), .src_b_imm(src_b_imm),
        .funct3(funct3), .is_jalr(is_jalr),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .redirect(redirect), .redirect_addr(redirect_addr)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [1:0] k, input logic [3:0] aop,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] im,
                                input logic [31:0] p, input logic [2:0] fl,
                                input logic [31:0] res, input logic rd,
                                input logic [31:0] ad, input int lat);
        vec_t v;
        v.k = k; v.aop = aop; v.f3 = f3; v.a = a; v.b = b; v.im = im;
        v.p = p; v.fl = fl; v.res = res; v.rd = rd; v.ad = ad; v.lat = lat;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        kind = v.k; alu_op = v.aop; funct3 = v.f3;
        rs1 = v.a; rs2 = v.b; imm = v.im; pc = v.p;
        src_a_pc = v.fl[2]; src_b_imm = v.fl[1]; is_jalr = v.fl[0];
    endtask

    task automatic issue(input vec_t v);
        int n = 0;
        @(negedge clock);
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
        end
        apply(v);
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int cyc, output bit rdy);
        cyc = 0;
        rdy = 1'b0;
        while (!out_valid && cyc < max) begin
            if (in_ready) rdy = 1'b1;
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 32'h0 || redirect !== 1'b0 ||
            redirect_addr !== 32'h0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset got v=%b res=%h rd=%b ad=%h rdy=%b required 0 0 0 0 1",
                     out_valid, result, redirect, redirect_addr, in_ready);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_alu();
        vec_t v[7];
        vec_t e;
        int cyc;
        bit rdy;
        v[0] = mk(0, 0, 0, 5, 0, 32'hFFFFFFFD, 0, 3'b010, 2, 0, 0, 0);
        v[1] = mk(0, 7, 0, 32'h80000000, 4, 0, 0, 3'b000, 32'hF8000000, 0, 0, 0);
        v[2] = mk(0, 1, 0, 0, 32'h10, 0, 32'h100, 3'b100, 32'hF0, 0, 0, 0);
        v[3] = mk(0, 3, 0, 32'hFFFFFFFF, 1, 0, 0, 3'b000, 1, 0, 0, 0);
        v[4] = mk(0, 4, 0, 32'hFFFFFFFF, 1, 0, 0, 3'b000, 0, 0, 0, 0);
        v[5] = mk(0, 2, 0, 1, 33, 0, 0, 3'b000, 2, 0, 0, 0);
        v[6] = mk(0, 12, 0, 32'h1234, 32'h55, 0, 0, 3'b000, 0, 0, 0, 0);
        foreach (v[i]) begin
            scb.push_back(v[i]);
            issue(v[i]);
            wait_valid(v[i].lat + 4, cyc, rdy);
            e = scb.pop_front();
            total++;
            if (out_valid !== 1'b1 || result !== e.res || redirect !== e.rd ||
                redirect_addr !== e.ad || cyc != e.lat) begin
                bad++;
                $display("FAIL alu[%0d] got v=%b res=%h rd=%b ad=%h lat=%0d required res=%h rd=%b ad=%h lat=%0d",
                         i, out_valid, result, redirect, redirect_addr, cyc,
                         e.res, e.rd, e.ad, e.lat);
            end
        end
    endtask

    task automatic test_branch_jump();
        vec_t v[6];
        vec_t e;
        int cyc;
        bit rdy;
        v[0] = mk(1, 0, 4, 32'hFFFFFFFF, 1, 32'h20, 32'h100, 0, 0, 1, 32'h120, 0);
        v[1] = mk(1, 0, 6, 32'hFFFFFFFF, 1, 32'h20, 32'h100, 0, 0, 0, 0, 0);
        v[2] = mk(1, 0, 0, 5, 5, 32'hFFFFFFF8, 32'h200, 0, 0, 1, 32'h1F8, 0);
        v[3] = mk(1, 0, 2, 5, 5, 32'h8, 32'h200, 0, 0, 0, 0, 0);
        v[4] = mk(2, 0, 0, 32'h1001, 0, 2, 32'h40, 3'b001, 32'h44, 1, 32'h1002, 0);
        v[5] = mk(2, 0, 0, 32'h1001, 0, 32'h10, 32'h40, 3'b000, 32'h44, 1, 32'h50, 0);
        foreach (v[i]) begin
            scb.push_back(v[i]);
            issue(v[i]);
            wait_valid(v[i].lat + 4, cyc, rdy);
            e = scb.pop_front();
            total++;
            if (out_valid !== 1'b1 || result !== e.res || redirect !== e.rd ||
                redirect_addr !== e.ad || cyc != e.lat) begin
                bad++;
                $display("FAIL brj[%0d] got v=%b res=%h rd=%b ad=%h lat=%0d required res=%h rd=%b ad=%h lat=%0d",
                         i, out_valid, result, redirect, redirect_addr, cyc,
                         e.res, e.rd, e.ad, e.lat);
            end
        end
    endtask

    task automatic test_muldiv();
        vec_t v[9];
        vec_t e;
        int cyc;
        bit rdy;
        v[0] = mk(3, 0, 4, 32'hFFFFFFF9, 2, 0, 0, 0, 32'hFFFFFFFD, 0, 0, 33);
        v[1] = mk(3, 0, 6, 32'hFFFFFFF9, 2, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 33);
        v[2] = mk(3, 0, 5, 32'h1234, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
        v[3] = mk(3, 0, 6, 32'h1234, 0, 0, 0, 0, 32'h1234, 0, 0, 0);
        v[4] = mk(3, 0, 4, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 32'h80000000, 0, 0, 0);
        v[5] = mk(3, 0, 6, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
        v[6] = mk(3, 0, 1, 32'h80000000, 32'h80000000, 0, 0, 0, 32'h40000000, 0, 0, 33);
        v[7] = mk(3, 0, 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFE, 0, 0, 33);
        v[8] = mk(3, 0, 0, 7, 32'hFFFFFFFD, 0, 0, 0, 32'hFFFFFFEB, 0, 0, 33);
        foreach (v[i]) begin
            scb.push_back(v[i]);
            issue(v[i]);
            wait_valid(v[i].lat + 4, cyc, rdy);
            e = scb.pop_front();
            total++;
            if (out_valid !== 1'b1 || result !== e.res || redirect !== 1'b0 ||
                cyc != e.lat || (e.lat > 0 && rdy)) begin
                bad++;
                $display("FAIL md[%0d] got v=%b res=%h rd=%b lat=%0d rdy_seen=%b required res=%h lat=%0d rdy_seen=0",
                         i, out_valid, result, redirect, cyc, rdy, e.res, e.lat);
            end
        end
    endtask

    task automatic test_random_md();
        vec_t e, v;
        int cyc;
        bit rdy;
        logic [31:0] a, b, r;
        logic [63:0] pu;
        logic signed [63:0] ps;
        logic [2:0] f3;
        int sel;
        for (int i = 0; i < 12; i++) begin
            a   = $urandom;
            b   = (i % 4 == 1) ? ($urandom & 32'hFF) : $urandom;
            if (i == 5) b = 0;
            sel = $urandom_range(0, 6);
            pu  = {32'h0, a} * {32'h0, b};
            ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            unique case (sel)
                0: begin f3 = 0; r = pu[31:0]; end
                1: begin f3 = 3; r = pu[63:32]; end
                2: begin f3 = 5; r = (b == 0) ? 32'hFFFFFFFF : a / b; end
                3: begin f3 = 7; r = (b == 0) ? a : a % b; end
                4: begin f3 = 1; r = ps[63:32]; end
                5: begin f3 = 4; r = (b == 0) ? 32'hFFFFFFFF : 32'($signed(a) / $signed(b)); end
                default: begin f3 = 6; r = (b == 0) ? a : 32'($signed(a) % $signed(b)); end
            endcase
            v = mk(3, 0, f3, a, b, 0, 0, 0, r, 0, 0, (f3[2] && b == 0) ? 0 : 33);
            scb.push_back(v);
            issue(v);
            wait_valid(v.lat + 4, cyc, rdy);
            e = scb.pop_front();
            total++;
            if (out_valid !== 1'b1 || result !== e.res || cyc != e.lat) begin
                bad++;
                $display("FAIL rnd[%0d] f3=%0d a=%h b=%h got v=%b res=%h lat=%0d required res=%h lat=%0d",
                         i, e.f3, e.a, e.b, out_valid, result, cyc, e.res, e.lat);
            end
        end
    endtask

    task automatic test_backpressure();
        vec_t v, e;
        int cyc;
        bit rdy;
        v = mk(3, 0, 2, 32'hFFFFFFFE, 3, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 33);
        scb.push_back(v);
        issue(v);
        out_ready = 1'b0;
        wait_valid(40, cyc, rdy);
        e = scb.pop_front();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || result !== e.res || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d] got v=%b res=%h rdy=%b required v=1 res=%h rdy=0",
                         i, out_valid, result, in_ready, e.res);
            end
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL release got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        vec_t v;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            v = mk(0, 0, 0, 32'(i * 7 + 1), 32'(100 + i), 0, 0, 0,
                   32'(i * 7 + 1 + 100 + i), 0, 0, 0);
            apply(v);
            in_valid = 1'b1;
            scb.push_back(v);
            @(posedge clock);
            #1;
            v = scb.pop_front();
            total++;
            if (out_valid !== 1'b1 || result !== v.res || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b[%0d] got v=%b res=%h rdy=%b required v=1 res=%h rdy=1",
                         i, out_valid, result, in_ready, v.res);
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        issue(mk(3, 0, 4, 100, 7, 0, 0, 0, 0, 0, 0, 33));
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        apply(mk(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
        end
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clock);
            #1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL flush_stale got out_valid_seen=%b required 0", seen);
        end
    endtask

    task automatic test_reset_busy();
        vec_t e;
        int cyc;
        bit rdy;
        issue(mk(3, 0, 5, 1000, 3, 0, 0, 0, 0, 0, 0, 33));
        repeat (5) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 32'h0 || redirect !== 1'b0 ||
            redirect_addr !== 32'h0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy got v=%b res=%h rd=%b ad=%h rdy=%b required 0 0 0 0 1",
                     out_valid, result, redirect, redirect_addr, in_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        scb.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 3, 0, 0, 0));
        issue(scb[0]);
        wait_valid(4, cyc, rdy);
        e = scb.pop_front();
        total++;
        if (out_valid !== 1'b1 || result !== e.res || cyc != 0) begin
            bad++;
            $display("FAIL after_reset got v=%b res=%h lat=%0d required v=1 res=%h lat=0",
                     out_valid, result, cyc, e.res);
        end
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        rs1 = '0; rs2 = '0; imm = '0; pc = '0; kind = '0; alu_op = '0;
        src_a_pc = 1'b0; src_b_imm = 1'b0; funct3 = '0; is_jalr = 1'b0;
        test_reset();
        test_alu();
        test_branch_jump();
        test_muldiv();
        test_random_md();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/execute_stage_mdu.md
# execute_stage_mdu

Parametrised, handshaked execute stage for the RV32/RV64 pipeline, sitting between decode/register-read and memory. It resolves ALU ops, conditional branches and JAL/JALR in one cycle, and adds a multi-cycle iterative multiply/divide unit for the M extension. It replaces the enable-stalled execute stage with a valid/ready interface and a registered one-entry output slot, so the stage can stall upstream while a mul/div is in flight and absorb downstream backpressure.

## Interface
- XLEN, 32 — datapath width (32 or 64).
- CNT_W, $clog2(XLEN+1) — iteration counter width.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an op.
- in_ready  out  1  stage accepts op this cycle.
- flush  in  1  kill the in-flight op and the output slot.
- rs1, rs2, imm, pc  in  XLEN each  operands; imm is already sign-extended.
- kind  in  2  00 ALU, 01 BRANCH, 10 JUMP, 11 MULDIV.
- alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10–15 give result 0.
- src_a_pc  in  1  ALU operand A = pc (else rs1).
- src_b_imm  in  1  ALU operand B = imm (else rs2).
- funct3  in  3  branch condition (0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU; 2/3 never taken) or mul/div op (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
- is_jalr  in  1  JUMP is JALR (else JAL).
- out_valid  out  1  output slot holds a result.
- out_ready  in  1  downstream consumes the slot.
- result  out  XLEN  writeback value.
- redirect  out  1  branch taken or jump.
- redirect_addr  out  XLEN  target address.

## Operation
- States: IDLE, BUSY, FIX.
- `in_ready` = (state == IDLE) && (!out_valid || out_ready). An op is accepted on an edge where `in_valid && in_ready && !flush`.
- **ALU:** computes A op B. Shift amount is B[log2(XLEN)-1:0]. `redirect` = 0, `redirect_addr` = 0.
- **BRANCH:** compares rs1 and rs2 per `funct3`. `result` = 0. `redirect` = condition. `redirect_addr` = pc + imm when taken, else 0.
- **JUMP:** `result` = pc + 4. `redirect` = 1. `redirect_addr` = (rs1 + imm) & ~1 for JALR, pc + imm for JAL.
- All additions wrap modulo 2^XLEN.
- **MULDIV accept:** latch operand magnitudes and result signs, clear the counter, go to BUSY.
  - Multiply: shift-add over magnitudes into a 2·XLEN product, one bit per edge.
  - Divide: restoring division, one quotient bit per edge.
  - After XLEN iterations, go to FIX.
  - FIX applies sign correction and selects the product low/high half, quotient or remainder.
  - When the output slot is free (!out_valid || out_ready), FIX writes the slot and returns to IDLE; otherwise it holds in FIX.
- Signs:
  - MULH: both operands signed. MULHSU: rs1 signed, rs2 unsigned.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
- Special cases complete at accept with single-cycle latency, never entering BUSY:
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Signed overflow (DIV/REM of most-negative by −1): quotient = rs1; remainder = 0.
- Output slot:
  - Loaded on completion; `out_valid` set.
  - Cleared by `out_ready` unless a new completion loads it on the same edge.
  - Contents stay stable while `out_valid && !out_ready`.
- **flush** (synchronous, highest priority): `out_valid` ← 0, state ← IDLE, counter ← 0, no accept that edge. `in_ready` may be 1 during flush, but no op is taken.
- **Reset:** state IDLE, counter 0, `out_valid` 0, `result` 0, `redirect` 0, `redirect_addr` 0, all internal registers 0. Reset mid-BUSY aborts the op.

## Timing
- ALU, BRANCH, JUMP and MULDIV special cases: accepted at edge E, visible on outputs after E (latency 1).
- MULDIV normal: accepted at edge E, iterations on edges E+1..E+XLEN, slot written at E+XLEN+1 at the earliest (XLEN+1 for XLEN=32 is 33 edges). `in_ready` is 0 from E until the slot is written.
- Back-to-back single-cycle ops sustain 1 op/cycle when `out_ready` = 1.
- Inputs are sampled only at accept; they may change freely during BUSY.

## Test plan
- ALU ADD, rs1 = 5, imm = −3, src_b_imm = 1 → one edge later: out_valid = 1, result = 2, redirect = 0. Then SRA 0x80000000 by 4 → 0xF8000000.
- BLT, rs1 = −1, rs2 = 1, pc = 0x100, imm = 0x20 → redirect = 1, redirect_addr = 0x120. Then BLTU with the same operands → redirect = 0.
- JALR, rs1 = 0x1001, imm = 2, pc = 0x40 → result = 0x44, redirect_addr = 0x1002.
- DIV −7/2 → result −3 after exactly 33 edges, with in_ready = 0 throughout. Then REM → −1. DIVU x/0 → 0xFFFFFFFF at latency 1. DIV 0x80000000/−1 → 0x80000000.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. Hold out_ready = 0 for 5 cycles at completion → FIX held, slot stable, in_ready = 0.
- Flush at iteration 10 of DIV → next edge: state IDLE, out_valid = 0, in_ready = 1. Assert reset_n low mid-BUSY → all outputs 0 immediately.
